// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant bundle between the requesting channels and the tristate bus arbiter.
// The bidirectional bus itself stays a plain inout net on the arbiter.
interface tristate_bus_arbiter_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    logic [N_CH-1:0]       req;
    logic [N_CH*WIDTH-1:0] din;
    logic [N_CH-1:0]       gnt;
    logic                  bus_oe;
    logic [WIDTH-1:0]      bus_rd;
    logic                  busy;
    logic                  err;

    modport master (output req, din, input gnt, bus_oe, bus_rd, busy, err);
    modport slave  (input req, din, output gnt, bus_oe, bus_rd, busy, err);
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus with hi-Z turnaround and hold limit.
// Optional contention detector enabled by defining BUS_CONTENTION_CHK_EN.
module tristate_bus_arbiter #(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 8,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tristate_bus_arbiter_if.slave  bif,
    inout  wire  [WIDTH-1:0]       bus
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN + 1);
    localparam logic [IW-1:0] LAST_RST = IW'(N_CH - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [TW-1:0] TURN_END = TW'(TURN - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

    state_t           r_state, w_state_next;
    logic [N_CH-1:0]  r_gnt, w_gnt_next;
    logic             r_oe, w_oe_next;
    logic [IW-1:0]    r_last, w_last_next;
    logic [HW-1:0]    r_hold, w_hold_next, w_hold_inc;
    logic [TW-1:0]    r_turn, w_turn_next;
    logic             r_busy;
    logic [WIDTH-1:0] r_bus_rd;

    logic [IW-1:0]    w_sel, w_idx;
    logic             w_found;
    logic [N_CH-1:0]  w_sel_oh;
    logic             w_owner_req, w_other_req;
    logic [WIDTH-1:0] w_drv_data;
    logic [WIDTH-1:0] w_din_arr [N_CH];

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_din
        assign w_din_arr[gi] = bif.din[gi*WIDTH +: WIDTH];
    end

    // r_last doubles as the current owner while in DRIVE
    assign w_drv_data = w_din_arr[r_last];
    assign bus        = r_oe ? w_drv_data : {WIDTH{1'bz}};

    // Search upward from the previous owner so it gets lowest priority
    always_comb begin
        w_sel   = r_last;
        w_idx   = r_last;
        w_found = 1'b0;
        for (int off = 1; off <= N_CH; off++) begin
            w_idx = IW'((int'(r_last) + off) % N_CH);
            if (!w_found && bif.req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_sel_oh    = N_CH'(1) << w_sel;
    assign w_owner_req = bif.req[r_last];
    assign w_other_req = |(bif.req & ~r_gnt);
    assign w_hold_inc  = (r_hold == HOLD_MAX) ? HOLD_MAX : r_hold + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_oe_next    = r_oe;
        w_last_next  = r_last;
        w_hold_next  = r_hold;
        w_turn_next  = r_turn;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_DRIVE;
                    w_gnt_next   = w_sel_oh;
                    w_oe_next    = 1'b1;
                    w_last_next  = w_sel;
                    w_hold_next  = '0;
                end
            end
            S_DRIVE: begin
                // w_hold_inc counts the current cycle, so an owner drives MAX_HOLD cycles
                w_hold_next = w_hold_inc;
                if (!w_owner_req || ((w_hold_inc == HOLD_MAX) && w_other_req)) begin
                    w_state_next = S_TURN;
                    w_gnt_next   = '0;
                    w_oe_next    = 1'b0;
                    w_turn_next  = '0;
                end
            end
            S_TURN: begin
                if (r_turn == TURN_END) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_turn_next = r_turn + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_gnt_next   = '0;
                w_oe_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_oe     <= 1'b0;
            r_last   <= LAST_RST;
            r_hold   <= '0;
            r_turn   <= '0;
            r_busy   <= 1'b0;
            r_bus_rd <= '0;
        end else begin
            r_state  <= w_state_next;
            r_gnt    <= w_gnt_next;
            r_oe     <= w_oe_next;
            r_last   <= w_last_next;
            r_hold   <= w_hold_next;
            r_turn   <= w_turn_next;
            r_busy   <= (w_state_next != S_IDLE);
            r_bus_rd <= bus;
        end
    end

    assign bif.gnt    = r_gnt;
    assign bif.bus_oe = r_oe;
    assign bif.bus_rd = r_bus_rd;
    assign bif.busy   = r_busy;

`ifdef BUS_CONTENTION_CHK_EN
    logic [WIDTH-1:0] r_drv_data;
    logic             r_drv_valid;
    logic             r_err;

    // bus_rd lags the bus by one cycle, so compare it with last cycle's driven data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drv_data  <= '0;
            r_drv_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_drv_data  <= w_drv_data;
            r_drv_valid <= r_oe;
            if (r_oe && r_drv_valid && (r_bus_rd != r_drv_data)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bif.err = r_err;
`else
    assign bif.err = 1'b0;
`endif

endmodule
